// File: rtl/ad4003_multi_acq_pkg.sv
// Shared encodings and sizing helpers for the AD4003 multi-channel readout engine.
package ad4003_pkg;

  localparam logic [1:0] MODE_RAW  = 2'd0;
  localparam logic [1:0] MODE_AVG  = 2'd1;
  localparam logic [1:0] MODE_TEST = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;

  // Headroom for summing 2^avg_max signed samples without overflow.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned avg_max);
    return data_w + avg_max;
  endfunction

endpackage

// File: rtl/ad4003_multi_acq_chan_accum.sv
// Per-channel deserializer, signed averaging accumulator and output register.
module ad4003_chan_accum
  import ad4003_pkg::*;
#(
  parameter int unsigned W            = 18,
  parameter int unsigned AVG_LOG2_MAX = 4,
  parameter int unsigned CH           = 0
) (
  input  logic         clk_100,
  input  logic         reset_n,
  input  logic         shift_en,
  input  logic         sdo,
  input  logic         acc_clr,
  input  logic         acc_add,
  input  logic         avg_out,
  input  logic         raw_out,
  input  logic         pat_out,
  input  logic [2:0]   avg_log2,
  input  logic [W-1:0] pat,
  output logic [W-1:0] data
);

  localparam int unsigned AW = acc_width(W, AVG_LOG2_MAX);

  logic [W-1:0]         shreg_q, shreg_d;
  logic [W-1:0]         data_q, data_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] acc_sum, acc_shr;

  always_comb begin
    shreg_d = shreg_q;
    if (shift_en) shreg_d = {shreg_q[W-2:0], sdo};

    acc_sum = acc_q + {{AVG_LOG2_MAX{shreg_q[W-1]}}, shreg_q};
    // Arithmetic shift floors toward -inf for negative sums.
    acc_shr = acc_sum >>> avg_log2;

    acc_d  = acc_q;
    data_d = data_q;
    if (acc_clr) acc_d = '0;
    if (acc_add) acc_d = acc_sum;
    if (avg_out) begin
      acc_d  = '0;
      data_d = acc_shr[W-1:0];
    end
    if (raw_out) data_d = shreg_q;
    if (pat_out) data_d = pat + W'(CH);
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      data_q  <= '0;
      acc_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/ad4003_multi_acq.sv
// N-channel AD4003 readout: drives CNV/SCK, shifts all SDO lines in parallel, raw/avg/test/hold output.
module ad4003_multi_acq
  import ad4003_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH = 18,
  parameter int unsigned ADC_CHANNELS   = 8,
  parameter int unsigned CONV_CYCLES    = 72,
  parameter int unsigned SCK_DIV        = 2,
  parameter int unsigned AVG_LOG2_MAX   = 4
) (
  input  logic                                   clk_100,
  input  logic                                   reset_n,
  input  logic                                   adc_start_conv,
  input  logic [1:0]                             mode,
  input  logic [2:0]                             avg_log2,
  input  logic                                   overrun_clr,
  input  logic [ADC_CHANNELS-1:0]                adc_sdo,
  output logic                                   adc_cnv,
  output logic                                   adc_sck,
  output logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_array_data,
  output logic                                   data_valid,
  output logic                                   busy,
  output logic                                   overrun
);

  localparam int unsigned W     = ADC_DATA_WIDTH;
  localparam int unsigned CC_W  = $clog2(CONV_CYCLES + 1);
  localparam int unsigned PH_W  = $clog2(2 * SCK_DIV);
  localparam int unsigned BIT_W = $clog2(W + 1);
  localparam int unsigned CW    = AVG_LOG2_MAX;
  localparam int unsigned SW    = AVG_LOG2_MAX + 1;
  localparam logic [2:0]  AVG_MAX = 3'(AVG_LOG2_MAX);

  logic [1:0]       state_q, state_d;
  logic [CC_W-1:0]  cnv_cnt_q, cnv_cnt_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [1:0]       mode_q, mode_d;
  logic [2:0]       avg_q, avg_d, avg_req;
  logic [CW-1:0]    smp_q, smp_d;
  logic [W-1:0]     pat_q, pat_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             start_ok, store, shift_en, avg_done;
  logic             acc_clr, acc_add, avg_out, raw_out, pat_out;

  always_comb begin
    avg_req  = (avg_log2 > AVG_MAX) ? AVG_MAX : avg_log2;
    start_ok = adc_start_conv && (state_q == ST_IDLE);
    store    = (state_q == ST_STORE);
    // Capture on the edge where SCK is driven 0->1.
    shift_en = (state_q == ST_SHIFT) && (ph_q == PH_W'(SCK_DIV - 1));
    avg_done = (({1'b0, smp_q} + SW'(1)) == (SW'(1) << avg_q));
    // A change of latched settings restarts averaging from a clean accumulator.
    acc_clr  = start_ok && ((mode != mode_q) || (avg_req != avg_q));
    acc_add  = store && (mode_q == MODE_AVG) && !avg_done;
    avg_out  = store && (mode_q == MODE_AVG) && avg_done;
    raw_out  = store && (mode_q == MODE_RAW);
    pat_out  = store && (mode_q == MODE_TEST);
    valid_d  = raw_out || avg_out || pat_out;

    smp_d = smp_q;
    if (acc_clr) smp_d = '0;
    if (store && (mode_q == MODE_AVG)) smp_d = avg_done ? '0 : smp_q + CW'(1);

    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (adc_start_conv && (state_q != ST_IDLE)) overrun_d = 1'b1;

    state_d   = state_q;
    cnv_cnt_d = cnv_cnt_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    mode_d    = mode_q;
    avg_d     = avg_q;
    pat_d     = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (adc_start_conv) begin
          state_d   = ST_CONV;
          cnv_cnt_d = '0;
          mode_d    = mode;
          avg_d     = avg_req;
        end
      end
      ST_CONV: begin
        if (cnv_cnt_q == CC_W'(CONV_CYCLES - 1)) begin
          state_d = ST_SHIFT;
          ph_d    = '0;
          bit_d   = '0;
        end else begin
          cnv_cnt_d = cnv_cnt_q + CC_W'(1);
        end
      end
      ST_SHIFT: begin
        if (ph_q == PH_W'(2 * SCK_DIV - 1)) begin
          ph_d = '0;
          if (bit_q == BIT_W'(W - 1)) state_d = ST_STORE;
          else                        bit_d   = bit_q + BIT_W'(1);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_STORE: begin
        state_d = ST_IDLE;
        if (pat_out) pat_d = pat_q + W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnv_cnt_q <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      mode_q    <= MODE_RAW;
      avg_q     <= '0;
      smp_q     <= '0;
      pat_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnv_cnt_q <= cnv_cnt_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      mode_q    <= mode_d;
      avg_q     <= avg_d;
      smp_q     <= smp_d;
      pat_q     <= pat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar k = 0; k < ADC_CHANNELS; k++) begin : g_ch
    ad4003_chan_accum #(
      .W            (W),
      .AVG_LOG2_MAX (AVG_LOG2_MAX),
      .CH           (k)
    ) u_ch (
      .clk_100  (clk_100),
      .reset_n  (reset_n),
      .shift_en (shift_en),
      .sdo      (adc_sdo[k]),
      .acc_clr  (acc_clr),
      .acc_add  (acc_add),
      .avg_out  (avg_out),
      .raw_out  (raw_out),
      .pat_out  (pat_out),
      .avg_log2 (avg_q),
      .pat      (pat_q),
      .data     (adc_array_data[W*k +: W])
    );
  end

  assign adc_cnv    = (state_q == ST_CONV);
  assign adc_sck    = (state_q == ST_SHIFT) && (ph_q >= PH_W'(SCK_DIV));
  assign busy       = (state_q != ST_IDLE);
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ad4003_multi_acq.sv
// Directed bench for ad4003_multi_acq: vector table of conversions plus overrun, reset and wrap sequences.
module tb_ad4003_multi_acq;

  logic             clk_100 = 1'b0;
  logic             reset_n;
  logic             adc_start_conv;
  logic [1:0]       mode;
  logic [2:0]       avg_log2;
  logic             overrun_clr;
  logic [7:0]       adc_sdo;
  logic             adc_cnv, adc_sck, data_valid, busy, overrun;
  logic [143:0]     adc_array_data;

  logic             s_start, s_clr, s_cnv, s_sck, s_valid, s_busy, s_ovr;
  logic [1:0]       s_mode, s_sdo;
  logic [2:0]       s_avg;
  logic [7:0]       s_data;

  always #5 clk_100 = ~clk_100;

  ad4003_multi_acq dut (
    .clk_100(clk_100), .reset_n(reset_n), .adc_start_conv(adc_start_conv), .mode(mode),
    .avg_log2(avg_log2), .overrun_clr(overrun_clr), .adc_sdo(adc_sdo), .adc_cnv(adc_cnv),
    .adc_sck(adc_sck), .adc_array_data(adc_array_data), .data_valid(data_valid),
    .busy(busy), .overrun(overrun)
  );

  ad4003_multi_acq #(
    .ADC_DATA_WIDTH(4), .ADC_CHANNELS(2), .CONV_CYCLES(3), .SCK_DIV(1), .AVG_LOG2_MAX(2)
  ) dut_s (
    .clk_100(clk_100), .reset_n(reset_n), .adc_start_conv(s_start), .mode(s_mode),
    .avg_log2(s_avg), .overrun_clr(s_clr), .adc_sdo(s_sdo), .adc_cnv(s_cnv),
    .adc_sck(s_sck), .adc_array_data(s_data), .data_valid(s_valid),
    .busy(s_busy), .overrun(s_ovr)
  );

  // ADC model: presents the next MSB-first bit after each SCK rising edge.
  logic [7:0][17:0] adc_words;
  int               sck_rises = 0;
  logic [4:0]       bidx;

  always @(posedge adc_cnv or posedge adc_sck) begin
    if (adc_cnv) sck_rises = 0;
    else         sck_rises = sck_rises + 1;
  end

  always_comb begin
    bidx = 5'(17 - sck_rises);
    for (int k = 0; k < 8; k++)
      adc_sdo[k] = (sck_rises < 18) ? adc_words[3'(k)][bidx] : 1'b0;
  end

  typedef struct {
    logic [1:0]       mode;
    logic [2:0]       avg;
    logic [7:0][17:0] w;
    logic             vld;
    logic [7:0][17:0] e;
  } vec_t;

  vec_t tbl[12];
  int   checks = 0;
  int   failures = 0;
  int   lat, cnv_hi, sck_up, valid_cnt, vtot;
  logic timed_out;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0][17:0] fill4(input logic [17:0] c0, c1, c2, rest);
    logic [7:0][17:0] r;
    for (int k = 0; k < 8; k++) r[k] = rest;
    r[0] = c0; r[1] = c1; r[2] = c2;
    return r;
  endfunction

  function automatic logic [7:0][17:0] pat_arr(input logic [17:0] p);
    logic [7:0][17:0] r;
    for (int k = 0; k < 8; k++) r[k] = p + 18'(k);
    return r;
  endfunction

  // n counts negedges after the edge that sampled the start (n=0 directly after it).
  task automatic run_conv(input logic [1:0] m, input logic [2:0] a, input logic [7:0][17:0] w,
                          input int extra_at, input logic extra_clr);
    logic prev_sck;
    adc_words = w; mode = m; avg_log2 = a;
    @(negedge clk_100); adc_start_conv = 1'b1;
    @(negedge clk_100); adc_start_conv = 1'b0;
    lat = -1; cnv_hi = 0; sck_up = 0; valid_cnt = 0; timed_out = 1'b1;
    prev_sck = adc_sck;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk_100);
      if (adc_cnv) cnv_hi++;
      if (adc_sck && !prev_sck) sck_up++;
      prev_sck = adc_sck;
      if (data_valid) begin
        valid_cnt++;
        if (lat < 0) lat = n;
      end
      if (n == extra_at) begin adc_start_conv = 1'b1; overrun_clr = extra_clr; end
      if (n == extra_at + 1) begin adc_start_conv = 1'b0; overrun_clr = 1'b0; end
      if (!busy) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic s_conv();
    @(negedge clk_100); s_start = 1'b1;
    @(negedge clk_100); s_start = 1'b0;
    lat = -1; valid_cnt = 0; timed_out = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (n > 0) @(negedge clk_100);
      if (s_valid) begin
        valid_cnt++;
        if (lat < 0) lat = n;
      end
      if (!s_busy) begin timed_out = 1'b0; break; end
    end
  endtask

  initial begin
    logic [7:0][17:0] r1, r2, wv;
    logic [7:0] s_exp [3];

    r1 = fill4(18'h2AAAA, 18'h3FFFF, 18'h00001, 18'h00001);
    r2 = fill4(18'h10001, 18'h20002, 18'h00003, 18'h0ABCD);
    tbl[0]  = '{2'd2, 3'd0, fill4(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF), 1'b1, pat_arr(18'd0)};
    tbl[1]  = '{2'd2, 3'd0, fill4(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF), 1'b1, pat_arr(18'd1)};
    tbl[2]  = '{2'd2, 3'd0, fill4(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF), 1'b1, pat_arr(18'd2)};
    tbl[3]  = '{2'd0, 3'd0, r1, 1'b1, r1};
    tbl[4]  = '{2'd3, 3'd0, fill4(18'h12345, 18'h12345, 18'h12345, 18'h12345), 1'b0, r1};
    tbl[5]  = '{2'd0, 3'd0, r2, 1'b1, r2};
    tbl[6]  = '{2'd1, 3'd2, fill4(18'h00004, 18'h3FFFF, 18'h00001, 18'h3FFFF), 1'b0, r2};
    tbl[7]  = '{2'd1, 3'd2, fill4(18'h00008, 18'h3FFFF, 18'h00001, 18'h3FFFF), 1'b0, r2};
    tbl[8]  = '{2'd1, 3'd2, fill4(18'h0000C, 18'h3FFFF, 18'h00001, 18'h3FFFF), 1'b0, r2};
    tbl[9]  = '{2'd1, 3'd2, fill4(18'h00010, 18'h00000, 18'h00002, 18'h3FFFF), 1'b1,
                fill4(18'h0000A, 18'h3FFFF, 18'h00001, 18'h3FFFF)};
    tbl[10] = '{2'd1, 3'd0, fill4(18'h20000, 18'h1FFFF, 18'h00000, 18'h3FFFE), 1'b1,
                fill4(18'h20000, 18'h1FFFF, 18'h00000, 18'h3FFFE)};
    tbl[11] = '{2'd0, 3'd5, fill4(18'h00000, 18'h3FFFF, 18'h2AAAA, 18'h15555), 1'b1,
                fill4(18'h00000, 18'h3FFFF, 18'h2AAAA, 18'h15555)};

    reset_n = 1'b0; adc_start_conv = 1'b0; mode = 2'd0; avg_log2 = 3'd0; overrun_clr = 1'b0;
    adc_words = '0;
    s_start = 1'b0; s_mode = 2'd2; s_avg = 3'd0; s_clr = 1'b0; s_sdo = '0;
    repeat (3) @(negedge clk_100);
    check("rst_data", adc_array_data, '0);
    check("rst_ctl", {adc_cnv, adc_sck, data_valid, busy, overrun}, '0);
    check("rst_small", {s_data, s_valid, s_busy, s_ovr, s_cnv, s_sck}, '0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_conv(tbl[i].mode, tbl[i].avg, tbl[i].w, -1, 1'b0);
      check($sformatf("v%0d_done", i), timed_out, 1'b0);
      check($sformatf("v%0d_lat", i), lat, tbl[i].vld ? 145 : -1);
      check($sformatf("v%0d_vcnt", i), valid_cnt, tbl[i].vld ? 1 : 0);
      check($sformatf("v%0d_cnv", i), cnv_hi, 72);
      check($sformatf("v%0d_sck", i), sck_up, 18);
      check($sformatf("v%0d_data", i), adc_array_data, tbl[i].e);
    end

    // avg_log2=7 clamps to 4: sixteen samples per strobe.
    vtot = 0;
    for (int i = 0; i < 15; i++) begin
      run_conv(2'd1, 3'd7, fill4(18'h10, 18'h10, 18'h10, 18'h10), -1, 1'b0);
      vtot += valid_cnt;
    end
    check("avg7_early", vtot, 0);
    run_conv(2'd1, 3'd7, fill4(18'h20, 18'h20, 18'h20, 18'h20), -1, 1'b0);
    check("avg7_vcnt", valid_cnt, 1);
    check("avg7_data", adc_array_data, fill4(18'h11, 18'h11, 18'h11, 18'h11));

    wv = fill4(18'h0F0F0, 18'h30303, 18'h00777, 18'h1C1C1);
    run_conv(2'd0, 3'd0, wv, 10, 1'b0);
    check("ovr_set", overrun, 1'b1);
    check("ovr_lat", lat, 145);
    check("ovr_vcnt", valid_cnt, 1);
    check("ovr_data", adc_array_data, wv);
    @(negedge clk_100); overrun_clr = 1'b1;
    @(negedge clk_100); overrun_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    run_conv(2'd0, 3'd0, wv, 10, 1'b1);
    check("ovr_win", overrun, 1'b1);

    // Reset asserted during bit 9 of the shift phase.
    adc_words = fill4(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF); mode = 2'd0;
    @(negedge clk_100); adc_start_conv = 1'b1;
    @(negedge clk_100); adc_start_conv = 1'b0;
    repeat (110) @(negedge clk_100);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_data", adc_array_data, '0);
    check("mid_rst_ctl", {adc_cnv, adc_sck, data_valid, busy, overrun}, '0);
    @(negedge clk_100); reset_n = 1'b1;
    wv = fill4(18'h00055, 18'h20000, 18'h01234, 18'h00002);
    run_conv(2'd0, 3'd0, wv, -1, 1'b0);
    check("post_rst_lat", lat, 145);
    check("post_rst_data", adc_array_data, wv);

    // Narrow instance: pattern counter wraps at 2^4.
    repeat (14) s_conv();
    s_exp[0] = 8'hFE; s_exp[1] = 8'h0F; s_exp[2] = 8'h10;
    for (int i = 0; i < 3; i++) begin
      s_conv();
      check($sformatf("wrap%0d_lat", i), lat, 12);
      check($sformatf("wrap%0d_data", i), s_data, s_exp[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
